// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide unit for the execute stage.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous active-low reset
//   i_valid      execute stage holds an M-extension op
//   i_funct3     op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   i_op_a       rs1 value (forwarded)
//   i_op_b       rs2 value (forwarded)
//   i_flush      execute-stage flush, aborts any in-flight op
//   i_hold       pipeline frozen by another source (cache stalls)
//   o_result     result, meaningful only while o_ready=1
//   o_ready      result valid this cycle (state DONE)
//   o_alu_stall  freezes the pipeline while an op is being computed
//
// Handshake: an op is accepted in IDLE on a cycle with i_valid=1 and i_flush=0.
// o_alu_stall is high from the accept cycle until the result is computed, so
// the pipeline keeps the instruction in place. o_ready is high for every cycle
// spent in DONE; the result is consumed on the first DONE cycle with i_hold=0,
// which is also the edge the pipeline advances, after which the unit is IDLE
// and a new op can be accepted the following cycle. i_valid is ignored outside
// IDLE and only latched operands are used after the accept cycle.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic [XLEN-1:0] o_result,
  output logic            o_ready,
  output logic            o_alu_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] a_q;        // multiplicand, or dividend / quotient shift register
  logic [XLEN-1:0] b_q;        // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q;      // partial remainder
  logic [XLEN-1:0] result_q;
  logic [4:0]      cnt_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  // Accept-side decode of the incoming op.
  logic            div_signed;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign div_signed  = !i_funct3[0];
  assign div_by_zero = (i_op_b == '0);
  assign div_ovf     = div_signed && (i_op_a == MIN_NEG) && (i_op_b == '1);
  // funct3[1] selects the remainder for divide ops.
  assign special_res = div_by_zero ? (i_funct3[1] ? i_op_a : '1)
                                   : (i_funct3[1] ? '0 : MIN_NEG);
  assign a_mag = (div_signed && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
  assign b_mag = (div_signed && i_op_b[XLEN-1]) ? -i_op_b : i_op_b;

  // Multiply: 33-bit extended operands give one signed multiplier for all
  // four variants. a is signed for MULH/MULHSU, b only for MULH.
  logic               mul_a_sx;
  logic               mul_b_sx;
  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN+1:0] product;
  logic [XLEN-1:0]          mul_d;

  assign mul_a_sx = (funct3_q[1:0] != 2'b11) && a_q[XLEN-1];
  assign mul_b_sx = (funct3_q[1:0] == 2'b01) && b_q[XLEN-1];
  assign mul_a    = {mul_a_sx, a_q};
  assign mul_b    = {mul_b_sx, b_q};
  assign product  = mul_a * mul_b;
  assign mul_d    = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0]
                                             : product[2*XLEN-1:XLEN];

  // Restoring divide step: shift in the next dividend bit, subtract the
  // divisor if it fits, record the quotient bit in the vacated LSB.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            quo_bit;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign rem_shift = {rem_q, a_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign quo_bit   = !rem_diff[XLEN];
  assign rem_d     = quo_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_d     = {a_q[XLEN-2:0], quo_bit};
  assign quo_fix   = neg_quo_q ? -quo_d : quo_d;
  assign rem_fix   = neg_rem_q ? -rem_d : rem_d;

  // The top product bits and funct3[2] carry no information once decoded.
  logic unused_ok;
  assign unused_ok = ^{product[2*XLEN+1:2*XLEN], funct3_q[2]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            funct3_q <= i_funct3;
            if (!i_funct3[2]) begin
              a_q     <= i_op_a;
              b_q     <= i_op_b;
              state_q <= S_MUL;
            end else if (div_by_zero || div_ovf) begin
              result_q <= special_res;
              state_q  <= S_DONE;
            end else begin
              a_q       <= a_mag;
              b_q       <= b_mag;
              rem_q     <= '0;
              neg_quo_q <= div_signed && (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
              neg_rem_q <= div_signed && i_op_a[XLEN-1];
              cnt_q     <= 5'd31;
              state_q   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          result_q <= mul_d;
          state_q  <= S_DONE;
        end
        S_DIV: begin
          a_q   <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == 5'd0) begin
            result_q <= funct3_q[1] ? rem_fix : quo_fix;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_DONE: begin
          if (!i_hold) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_result    = result_q;
  assign o_ready     = (state_q == S_DONE);
  // Deliberately independent of i_flush/i_hold: the control unit feeds those
  // back from this stall, so depending on them would form a loop.
  assign o_alu_stall = ((state_q == S_IDLE) && i_valid) ||
                       (state_q == S_MUL) || (state_q == S_DIV);

endmodule
